// File: rtl/bp_be_fp_result_sink.sv
// Writeback sink for the FMA pipe: buffers integer-multiply and FP results in
// credit-managed FIFOs, squashes post-flush stragglers and accumulates FP flags.

module bp_be_fp_result_fifo #(
  parameter int width_p = 71,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               flush_i,
  input  logic               drop_i,
  input  logic               issue_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic               pop_o,
  output logic               credit_o
);
  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [cnt_w-1:0]   count_reg, inflight_reg;
  logic [cnt_w:0]     used;
  logic               arrive_live, enq, pop, issue_eff;

  // An arrival only retires an in-flight op if one is outstanding; otherwise it is noise.
  assign arrive_live = v_i && (inflight_reg != '0);
  assign enq         = arrive_live && !flush_i && !drop_i;
  assign issue_eff   = issue_i && !flush_i;
  assign v_o         = (count_reg != '0);
  assign pop         = yumi_i && v_o;
  assign pop_o       = pop;
  assign data_o      = mem[rd_ptr_reg];
  assign used        = {1'b0, count_reg} + {1'b0, inflight_reg};
  assign credit_o    = (used < (cnt_w+1)'(els_p));

  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr_reg] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      inflight_reg <= '0;
    end else begin
      inflight_reg <= inflight_reg + cnt_w'(issue_eff) - cnt_w'(arrive_live);
      if (flush_i) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (enq) wr_ptr_reg <= wr_ptr_reg + ptr_w'(1);
        if (pop) rd_ptr_reg <= rd_ptr_reg + ptr_w'(1);
        count_reg <= count_reg + cnt_w'(enq) - cnt_w'(pop);
      end
    end
  end

  a_issue_credit: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(issue_i && !flush_i && !credit_o));
  a_enq_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(enq && (count_reg == cnt_w'(els_p)) && !pop));
endmodule

module bp_be_fp_result_sink #(
  parameter int data_width_p  = 66,
  parameter int els_p         = 4,
  parameter int drop_cycles_p = 5
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    issue_imul_i,
  input  logic                    issue_fma_i,
  output logic                    imul_credit_o,
  output logic                    fma_credit_o,
  input  logic                    imul_v_i,
  input  logic [data_width_p-1:0] imul_data_i,
  input  logic [4:0]              imul_rd_i,
  input  logic                    fma_v_i,
  input  logic [data_width_p-1:0] fma_data_i,
  input  logic [4:0]              fma_fflags_i,
  input  logic [4:0]              fma_rd_i,
  input  logic                    flush_i,
  output logic                    iwb_v_o,
  output logic [data_width_p-1:0] iwb_data_o,
  output logic [4:0]              iwb_rd_o,
  input  logic                    iwb_yumi_i,
  output logic                    fwb_v_o,
  output logic [data_width_p-1:0] fwb_data_o,
  output logic [4:0]              fwb_rd_o,
  input  logic                    fwb_yumi_i,
  output logic [4:0]              fflags_o,
  input  logic                    fflags_clear_i
);
  localparam int drop_w = $clog2(drop_cycles_p + 1);
  localparam int iw     = data_width_p + 5;
  localparam int fw     = data_width_p + 10;

  logic [drop_w-1:0] drop_cnt_reg;
  logic              drop_active;
  logic [4:0]        fflags_reg, fflags_next, head_fflags;
  logic [iw-1:0]     imul_head;
  logic [fw-1:0]     fma_head;
  logic              imul_pop, fma_pop;

  assign drop_active = (drop_cnt_reg != '0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)       drop_cnt_reg <= '0;
    else if (flush_i)     drop_cnt_reg <= drop_w'(drop_cycles_p);
    else if (drop_active) drop_cnt_reg <= drop_cnt_reg - drop_w'(1);
  end

  bp_be_fp_result_fifo #(.width_p(iw), .els_p(els_p)) imul_fifo (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i), .drop_i(drop_active),
    .issue_i(issue_imul_i), .v_i(imul_v_i), .data_i({imul_data_i, imul_rd_i}),
    .yumi_i(iwb_yumi_i), .v_o(iwb_v_o), .data_o(imul_head), .pop_o(imul_pop),
    .credit_o(imul_credit_o)
  );

  bp_be_fp_result_fifo #(.width_p(fw), .els_p(els_p)) fma_fifo (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i), .drop_i(drop_active),
    .issue_i(issue_fma_i), .v_i(fma_v_i), .data_i({fma_data_i, fma_rd_i, fma_fflags_i}),
    .yumi_i(fwb_yumi_i), .v_o(fwb_v_o), .data_o(fma_head), .pop_o(fma_pop),
    .credit_o(fma_credit_o)
  );

  assign {iwb_data_o, iwb_rd_o}              = imul_head;
  assign {fwb_data_o, fwb_rd_o, head_fflags} = fma_head;

  // Flags only become architectural when the result is actually written back.
  always_comb begin
    fflags_next = fflags_reg;
    if (fflags_clear_i) fflags_next = fma_pop ? head_fflags : 5'b0;
    else if (fma_pop)   fflags_next = fflags_reg | head_fflags;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) fflags_reg <= '0;
    else            fflags_reg <= fflags_next;
  end

  assign fflags_o = fflags_reg;

  // imul_pop is consumed only for symmetry with the fma path.
  logic unused_ok;
  assign unused_ok = imul_pop;
endmodule

// File: doc/bp_be_fp_result_sink.md
BP_BE_FP_RESULT_SINK -- requirements
Module: bp_be_fp_result_sink

Interface
REQ-001 Parameter data_width_p, default 66; writeback data width (recoded FP register width).
REQ-002 Parameter els_p, default 4; depth of each result FIFO, power of two, >=2.
REQ-003 Parameter drop_cycles_p, default 5; post-flush window (>= longest pipe latency) during which arriving results are discarded.
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_n_i  in  1  reset, asynchronous, active-low.
REQ-006 issue_imul_i / issue_fma_i  in  1 each  dispatch of one op to the imul / fma pipe this cycle.
REQ-007 imul_credit_o / fma_credit_o  out  1 each  high when one more op of that kind may be issued.
REQ-008 imul_v_i, imul_data_i [data_width_p], imul_rd_i [5]  in  integer multiply result from the FMA pipe.
REQ-009 fma_v_i, fma_data_i [data_width_p], fma_fflags_i [5], fma_rd_i [5]  in  FP result from the FMA pipe.
REQ-010 flush_i  in  1  squash all buffered and in-flight results.
REQ-011 iwb_v_o, iwb_data_o [data_width_p], iwb_rd_o [5]  out; iwb_yumi_i  in  integer regfile write port, valid-then-yumi.
REQ-012 fwb_v_o, fwb_data_o [data_width_p], fwb_rd_o [5]  out; fwb_yumi_i  in  FP regfile write port, valid-then-yumi.
REQ-013 fflags_o  out  5  sticky accumulated FP exception flags (NV,DZ,OF,UF,NX); fflags_clear_i  in  1  clears them.

Function
REQ-014 Two independent in-order FIFOs (imul, fma), each els_p entries: {data, rd} for imul, {data, rd, fflags} for fma.
REQ-015 Result with *_v_i high in cycle N (not dropped) appears at FIFO head no earlier than N+1; no combinational path from *_v_i to *wb_v_o.
REQ-016 *wb_v_o = FIFO non-empty; *wb_data_o/*wb_rd_o = head entry, stable while v_o high and yumi low.
REQ-017 *wb_yumi_i asserted only when matching v_o high; pops head at that edge.
REQ-018 Simultaneous enqueue and pop on a full or empty FIFO legal; occupancy unchanged when full, passes entry through at N+1 when empty.
REQ-019 Per pipe, used = occupancy + inflight (counter width $clog2(els_p+1)); credit_o = (used < els_p).
REQ-020 issue_* increments inflight; non-dropped arrival moves one from inflight to occupancy; pop decrements occupancy; simultaneous issue and pop leaves used unchanged.
REQ-021 issue_* with credit_o low, or arrival into a full FIFO, is illegal; simulation assertion fires.
REQ-022 flush_i: at that edge both FIFOs empty (occupancy 0); drop counter loads drop_cycles_p; issue_* in the flush cycle ignored; yumi in the flush cycle has no additional effect.
REQ-023 Drop window = drop counter nonzero (decrements 1 per cycle to 0); every arrival in the window discarded and decrements inflight; flush during window reloads counter.
REQ-024 Arrival with inflight already 0 (within or outside window) discarded, no counter underflow.
REQ-025 fflags_o |= head fflags on each fwb pop; flags of flushed/dropped results never accumulate.
REQ-026 fflags_clear_i with no pop: fflags_o <- 0; with simultaneous pop: fflags_o <- popped fflags only.
REQ-027 imul and fma paths fully independent; both may arrive, pop and issue same cycle.

Reset
REQ-028 While reset_n_i low (asynchronous assert): FIFOs empty, inflight 0, drop counter 0, fflags_o 0; thus iwb_v_o=fwb_v_o=0, imul_credit_o=fma_credit_o=1.
REQ-029 Deassertion synchronous to clk_i; reset mid-operation discards all buffered and in-flight state; later arrivals treated per REQ-024.

Verification
REQ-030 Issue 4 fma (els_p=4), no yumi -> fma_credit_o=0 after 4th issue; 4 arrivals queue; first fwb_yumi_i -> fma_credit_o=1 next cycle.
REQ-031 fma arrivals fflags 5'b00001 then 5'b10000, both popped -> fflags_o=5'b10001; then clear with pop of 5'b00100 -> fflags_o=5'b00100.
REQ-032 3 fma issued, 1 buffered, 2 in flight; flush_i; 2 arrivals within 5 cycles -> fwb_v_o stays 0, fflags_o unchanged, fma_credit_o=1, used=0.
REQ-033 imul arrival data 0x1234, rd 7 into empty FIFO with iwb_yumi_i held high -> iwb_v_o=1, data 0x1234, rd 7 next cycle, popped that cycle.
REQ-034 reset_n_i pulled low mid-burst between clock edges -> all v_o 0 and credits 1 immediately, before next edge.
